// File: rtl/mpadder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mpadder_seq
//  Description : Multi-precision adder/subtractor. Operands are latched on
//                start; carries ripple chunk-serially, one CHUNK_W-bit chunk
//                per clock, through a registered carry. Four modes:
//                A+B, A-B, A+B+1, B-A. start/busy/done handshake, results
//                held until the next accepted start.
//  Revision    : 1.0 - initial release
// ============================================================================
module mpadder_seq #(
    parameter int W       = 1027,
    parameter int CHUNK_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         busy,
    output logic         done,
    output logic [W:0]   result,
    output logic         borrow
);

    // Number of compute cycles, width of the final (possibly partial) chunk.
    localparam int c_n_chunks = (W + CHUNK_W - 1) / CHUNK_W;
    localparam int c_last_w   = W - (c_n_chunks - 1) * CHUNK_W;
    localparam int c_cnt_w    = (c_n_chunks > 1) ? $clog2(c_n_chunks) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_n_chunks - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [1:0]           r_op;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [W:0]           r_result;
    logic                 r_borrow;

    logic                 w_sub;
    logic                 w_last;
    logic [W-1:0]         w_x;
    logic [W-1:0]         w_y;
    logic [31:0]          w_shift;
    logic [CHUNK_W-1:0]   w_xc;
    logic [CHUNK_W-1:0]   w_yc;
    logic [CHUNK_W:0]     w_sum;
    logic                 w_cout;
    logic [W-1:0]         w_mask;
    logic [W-1:0]         w_ins;
    logic [W-1:0]         w_res_lo;

    // Modes 01 and 11 are the subtract modes; both have op[0] set.
    assign w_sub  = r_op[0];
    assign w_last = (r_cnt == c_last_idx);

    // Operand preparation: reverse-subtract swaps the operands and inverts A,
    // subtract inverts B. Inversion only touches the W real bits, so the
    // zero-filling right shift below leaves the last chunk's pad bits at 0.
    always_comb begin
        w_x = r_a;
        w_y = r_b;
        case (r_op)
            2'b01:   w_y = ~r_b;
            2'b11: begin
                w_x = r_b;
                w_y = ~r_a;
            end
            default: ;
        endcase
    end

    assign w_shift = 32'(r_cnt) * CHUNK_W;
    assign w_xc    = CHUNK_W'(w_x >> w_shift);
    assign w_yc    = CHUNK_W'(w_y >> w_shift);
    assign w_sum   = {1'b0, w_xc} + {1'b0, w_yc} + (CHUNK_W + 1)'(r_carry);

    // In a partial last chunk the pad bits are zero, so the carry out of
    // bit W-1 lands exactly at sum position c_last_w.
    assign w_cout  = w_last ? w_sum[c_last_w] : w_sum[CHUNK_W];

    // Merge the new chunk into the result; bits shifted above W-1 drop out.
    assign w_mask   = W'({CHUNK_W{1'b1}}) << w_shift;
    assign w_ins    = W'(w_sum[CHUNK_W-1:0]) << w_shift;
    assign w_res_lo = (r_result[W-1:0] & ~w_mask) | w_ins;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one RUN cycle per chunk, then a single FIN cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on an accepted start, then one chunk per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 2'b00;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_op    <= op;
                        r_carry <= (op != 2'b00);
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_result[W-1:0] <= w_res_lo;
                    r_carry         <= w_cout;
                    if (w_last) begin
                        // Subtract: no carry out means minuend < subtrahend.
                        r_result[W] <= w_cout ^ w_sub;
                        r_borrow    <= w_sub & ~w_cout;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FIN);
    assign result = r_result;
    assign borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_mpadder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mpadder_seq
//  Description : Self-checking bench for mpadder_seq. Three instances
//                (CHUNK_W = 64, 42, 1027) share operands; a vector table,
//                random operations against a wide-arithmetic model, an
//                ignored-restart sequence and a mid-run reset are checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mpadder_seq;

    localparam int W = 1027;

    logic         clk;
    logic         reset;
    logic [2:0]   st;
    logic [1:0]   op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         busy_v   [3];
    logic         done_v   [3];
    logic [W:0]   res_v    [3];
    logic         bor_v    [3];

    int n_cmp;
    int n_bad;

    // Edges from the start edge (inclusive) until done is seen.
    int exp_lat [3] = '{18, 26, 2};

    mpadder_seq #(.W(W), .CHUNK_W(64)) u_dut64 (
        .clk(clk), .reset(reset), .start(st[0]), .op(op), .in_a(in_a), .in_b(in_b),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .borrow(bor_v[0])
    );
    mpadder_seq #(.W(W), .CHUNK_W(42)) u_dut42 (
        .clk(clk), .reset(reset), .start(st[1]), .op(op), .in_a(in_a), .in_b(in_b),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .borrow(bor_v[1])
    );
    mpadder_seq #(.W(W), .CHUNK_W(W)) u_dut1027 (
        .clk(clk), .reset(reset), .start(st[2]), .op(op), .in_a(in_a), .in_b(in_b),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .borrow(bor_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare; on failure report top nibble, low 64 bits and lowest differing bit.
    task automatic chk(input string nm, input int d, input logic [W:0] got, input logic [W:0] exp);
        logic [W:0] diff;
        int         pos;
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            diff = got ^ exp;
            pos  = -1;
            for (int i = W; i >= 0; i--) if (diff[i] !== 1'b0) pos = i;
            $display("FAIL %s dut%0d: got top=%h low=%h, expected top=%h low=%h (first diff bit %0d)",
                     nm, d, got[W:W-3], got[63:0], exp[W:W-3], exp[63:0], pos);
        end
    endtask

    // Reference: plain W+1-bit arithmetic straight from the mode definitions.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W:0] r, output logic br);
        logic [W:0] ea;
        logic [W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        br = 1'b0;
        case (o)
            2'b00: r = ea + eb;
            2'b01: begin r = ea - eb; br = (a < b); end
            2'b10: r = ea + eb + (W + 1)'(1);
            default: begin r = eb - ea; br = (b < a); end
        endcase
    endtask

    task automatic rand_wide(output logic [W-1:0] v);
        logic [33*32-1:0] t;
        for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
        v = W'(t);
        if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, W);
    endtask

    // Launch one operation on all three instances and watch for 40 cycles.
    // restart_cyc > 0 pulses a second start (other operands) on the two
    // multi-cycle instances while they are still busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W:0] er, input logic eb,
                          input int restart_cyc);
        int         cnt  [3];
        int         lat  [3];
        logic [W:0] gres [3];
        logic       gbor [3];
        logic       bbad [3];
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0; lat[d] = 0; gres[d] = '0; gbor[d] = 1'b0; bbad[d] = 1'b0;
        end
        @(negedge clk);
        op = o; in_a = a; in_b = b; st = 3'b111;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                st = 3'b000; in_a = ~a; in_b = ~b; op = ~o;
            end
            if (restart_cyc > 0 && cyc == restart_cyc) begin
                st = 3'b011; in_a = a ^ {W{1'b1}} >> 3; in_b = b + W'(12345); op = o + 2'd1;
            end
            if (restart_cyc > 0 && cyc == restart_cyc + 1) st = 3'b000;
            for (int d = 0; d < 3; d++) begin
                if (done_v[d] === 1'b1) begin
                    if (cnt[d] == 0) begin
                        lat[d] = cyc; gres[d] = res_v[d]; gbor[d] = bor_v[d];
                    end
                    cnt[d]++;
                end
                if ((cyc <= exp_lat[d] && busy_v[d] !== 1'b1) ||
                    (cyc == exp_lat[d] + 1 && busy_v[d] !== 1'b0)) bbad[d] = 1'b1;
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk({tag, " done_pulses"}, d, (W + 1)'(cnt[d]), (W + 1)'(1));
            chk({tag, " latency"},     d, (W + 1)'(lat[d]), (W + 1)'(exp_lat[d]));
            chk({tag, " result"},      d, gres[d], er);
            chk({tag, " borrow"},      d, (W + 1)'(gbor[d]), (W + 1)'(eb));
            chk({tag, " busy_profile"}, d, (W + 1)'(bbad[d]), '0);
            chk({tag, " result_held"}, d, res_v[d], er);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   res;
        logic         bor;
    } vec_t;

    vec_t         tv [8];
    logic [W-1:0] ones;
    logic [W:0]   bit_w;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   ro;
    logic [W:0]   mr;
    logic         mb;
    int           ndone;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ones  = '1;
        bit_w = (W + 1)'(1) << W;

        tv[0] = '{2'b00, ones,      ones,       {ones, 1'b0},  1'b0};
        tv[1] = '{2'b01, W'(5),     W'(7),      {ones, 1'b0},  1'b1};
        tv[2] = '{2'b01, W'(7),     W'(5),      (W + 1)'(2),   1'b0};
        tv[3] = '{2'b11, W'(3),     W'(10),     (W + 1)'(7),   1'b0};
        tv[4] = '{2'b10, ones,      W'(0),      bit_w,         1'b0};
        tv[5] = '{2'b00, ones,      W'(1),      bit_w,         1'b0};
        tv[6] = '{2'b01, W'(0),     W'(1),      {1'b1, ones},  1'b1};
        tv[7] = '{2'b11, W'(5),     W'(5),      (W + 1)'(0),   1'b0};

        reset = 1'b1; st = 3'b000; op = 2'b00; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset busy",   d, (W + 1)'(busy_v[d]), '0);
            chk("reset done",   d, (W + 1)'(done_v[d]), '0);
            chk("reset result", d, res_v[d], '0);
            chk("reset borrow", d, (W + 1)'(bor_v[d]), '0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Vector table.
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].bor, 0);

        // Random operations against the model.
        for (int i = 0; i < 12; i++) begin
            rand_wide(ra);
            rand_wide(rb);
            ro = 2'($urandom_range(0, 3));
            model(ro, ra, rb, mr, mb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, mr, mb, 0);
        end

        // Start pulsed again mid-run with different operands: must be ignored.
        rand_wide(ra);
        rand_wide(rb);
        model(2'b01, ra, rb, mr, mb);
        run_op("restart_ignored", 2'b01, ra, rb, mr, mb, 5);

        // Reset asserted mid-RUN: outputs clear immediately, no done pulse.
        @(negedge clk);
        op = 2'b00; in_a = ones; in_b = W'(1); st = 3'b111;
        @(posedge clk);
        #1 st = 3'b000;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("midreset busy",   d, (W + 1)'(busy_v[d]), '0);
            chk("midreset done",   d, (W + 1)'(done_v[d]), '0);
            chk("midreset result", d, res_v[d], '0);
            chk("midreset borrow", d, (W + 1)'(bor_v[d]), '0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) if (done_v[d] !== 1'b0) ndone++;
        end
        chk("midreset no_done", 0, (W + 1)'(ndone), '0);

        rand_wide(ra);
        rand_wide(rb);
        model(2'b11, ra, rb, mr, mb);
        run_op("after_reset", 2'b11, ra, rb, mr, mb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
